requant_round_pipe: RTL

Multi-channel, elastic-pipelined requantiser for fixed-point vectors. It is the successor of the single-channel unbiased rounder. It adds a runtime right-shift, four selectable rounding modes, a valid/ready handshake, per-channel saturation flags and a sticky saturation counter. It sits between wide accumulators (filters, MACs) and narrow downstream datapaths or streaming interfaces.

---
 rtl/requant_pkg.sv | 35 +++
 rtl/requant_round_pipe_if.sv | 36 +++
 rtl/requant_lane.sv | 118 +++++++++++
 rtl/requant_round_pipe.sv | 100 ++++++++++
 4 files changed

// File: rtl/requant_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | requant_pkg                                                          |
// | Shared rounding-mode / remainder-class types and clamp-bound helpers.|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package requant_pkg;

  typedef enum logic [1:0] {
    RND_HALF_EVEN = 2'd0,
    RND_HALF_AWAY = 2'd1,
    RND_TRUNC     = 2'd2,
    RND_HALF_UP   = 2'd3
  } rnd_mode_e;

  // Remainder relative to the half point, enough to decide every mode later.
  typedef enum logic [1:0] {
    RC_ZERO = 2'd0,
    RC_LOW  = 2'd1,
    RC_HALF = 2'd2,
    RC_HIGH = 2'd3
  } rem_class_e;

  function automatic logic signed [63:0] sat_max(input int width, input bit is_signed);
    if (is_signed) return (64'sd1 <<< (width - 1)) - 64'sd1;
    return (64'sd1 <<< width) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int width, input bit is_signed);
    if (is_signed) return -(64'sd1 <<< (width - 1));
    return 64'sd0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/requant_round_pipe_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | requant_round_pipe_if                                                |
// | Stream-in / stream-out bundle plus saturation counter access.        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface requant_round_pipe_if #(
  parameter int WIDTH_IN  = 32,
  parameter int WIDTH_OUT = 16,
  parameter int NUM_CH    = 4,
  parameter int SHIFT_W   = 6,
  parameter int CNT_W     = 16
);
  logic                          s_valid;
  logic                          s_ready;
  logic [NUM_CH*WIDTH_IN-1:0]    s_data;
  logic [SHIFT_W-1:0]            s_shift;
  logic [1:0]                    s_mode;
  logic                          m_valid;
  logic                          m_ready;
  logic [NUM_CH*WIDTH_OUT-1:0]   m_data;
  logic [NUM_CH-1:0]             m_sat;
  logic [CNT_W-1:0]              sat_count;
  logic                          clr_count;

  modport master (
    output s_valid, s_data, s_shift, s_mode, m_ready, clr_count,
    input  s_ready, m_valid, m_data, m_sat, sat_count
  );

  modport slave (
    input  s_valid, s_data, s_shift, s_mode, m_ready, clr_count,
    output s_ready, m_valid, m_data, m_sat, sat_count
  );
endinterface
`default_nettype wire

// File: rtl/requant_lane.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | requant_lane                                                         |
// | One channel: stage 1 shift/remainder class, stage 2 round + clamp.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module requant_lane
  import requant_pkg::*;
#(
  parameter int WIDTH_IN  = 32,
  parameter int WIDTH_OUT = 16,
  parameter int IS_SIGNED = 1,
  parameter int SHIFT_W   = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_ld1,
  input  logic                 i_ld2,
  input  logic [WIDTH_IN-1:0]  i_x,
  input  logic [SHIFT_W-1:0]   i_shift,
  input  rnd_mode_e            i_mode,
  output logic [WIDTH_OUT-1:0] o_y,
  output logic                 o_sat
);

  localparam logic [SHIFT_W-1:0]  c_max_shift = SHIFT_W'(WIDTH_IN);
  localparam logic signed [63:0]  c_hi        = sat_max(WIDTH_OUT, IS_SIGNED != 0);
  localparam logic signed [63:0]  c_lo        = sat_min(WIDTH_OUT, IS_SIGNED != 0);

  logic [SHIFT_W-1:0]  w_s;
  logic                w_fill;
  logic [WIDTH_IN-1:0] w_q;
  logic [WIDTH_IN:0]   w_r;
  logic [WIDTH_IN:0]   w_h;
  rem_class_e          w_cls;

  logic [WIDTH_IN-1:0] r_q;
  rem_class_e          r_cls;
  logic                r_neg;

  logic                w_up;
  logic [WIDTH_IN:0]   w_sum;
  logic                w_ext;
  logic signed [63:0]  w_sum_ext;
  logic [WIDTH_OUT-1:0] w_y;
  logic                w_clip;

  logic [WIDTH_OUT-1:0] r_y;
  logic                 r_sat;

  assign w_s    = (i_shift > c_max_shift) ? c_max_shift : i_shift;
  assign w_fill = (IS_SIGNED != 0) && i_x[WIDTH_IN-1];
  // Shifting a double-width sign-filled word gives floor() even at s == WIDTH_IN.
  assign w_q    = WIDTH_IN'({{WIDTH_IN{w_fill}}, i_x} >> w_s);
  assign w_r    = {1'b0, i_x} & ~({(WIDTH_IN+1){1'b1}} << w_s);
  assign w_h    = ({{WIDTH_IN{1'b0}}, 1'b1} << w_s) >> 1;

  always_comb begin
    w_cls = RC_HIGH;
    if (w_r == '0)       w_cls = RC_ZERO;
    else if (w_r < w_h)  w_cls = RC_LOW;
    else if (w_r == w_h) w_cls = RC_HALF;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q   <= '0;
      r_cls <= RC_ZERO;
      r_neg <= 1'b0;
    end else if (i_ld1) begin
      r_q   <= w_q;
      r_cls <= w_cls;
      r_neg <= w_fill;
    end
  end

  always_comb begin
    w_up = 1'b0;
    case (i_mode)
      RND_HALF_EVEN: w_up = (r_cls == RC_HIGH) || ((r_cls == RC_HALF) && r_q[0]);
      RND_HALF_AWAY: w_up = (r_cls == RC_HIGH) || ((r_cls == RC_HALF) && !r_neg);
      RND_TRUNC:     w_up = r_neg && (r_cls != RC_ZERO);
      RND_HALF_UP:   w_up = (r_cls == RC_HALF) || (r_cls == RC_HIGH);
      default:       w_up = 1'b0;
    endcase
  end

  assign w_sum     = {((IS_SIGNED != 0) ? r_q[WIDTH_IN-1] : 1'b0), r_q} + {{WIDTH_IN{1'b0}}, w_up};
  assign w_ext     = (IS_SIGNED != 0) && w_sum[WIDTH_IN];
  assign w_sum_ext = {{(63-WIDTH_IN){w_ext}}, w_sum};

  always_comb begin
    w_y    = w_sum[WIDTH_OUT-1:0];
    w_clip = 1'b0;
    if (w_sum_ext > c_hi) begin
      w_y    = WIDTH_OUT'(c_hi);
      w_clip = 1'b1;
    end else if (w_sum_ext < c_lo) begin
      w_y    = WIDTH_OUT'(c_lo);
      w_clip = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_y   <= '0;
      r_sat <= 1'b0;
    end else if (i_ld2) begin
      r_y   <= w_y;
      r_sat <= w_clip;
    end
  end

  assign o_y   = r_y;
  assign o_sat = r_sat;

endmodule
`default_nettype wire

// File: rtl/requant_round_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | requant_round_pipe                                                   |
// | Multi-channel 2-stage elastic requantiser with saturation counting.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module requant_round_pipe
  import requant_pkg::*;
#(
  parameter int WIDTH_IN  = 32,
  parameter int WIDTH_OUT = 16,
  parameter int IS_SIGNED = 1,
  parameter int NUM_CH    = 4,
  parameter int SHIFT_W   = 6,
  parameter int CNT_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  requant_round_pipe_if.slave   bus
);

  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  if (WIDTH_OUT > WIDTH_IN) begin : g_err_width
    $error("requant_round_pipe: WIDTH_OUT must not exceed WIDTH_IN");
  end
  if (NUM_CH < 1) begin : g_err_ch
    $error("requant_round_pipe: NUM_CH must be at least 1");
  end
  if ((64'd1 << SHIFT_W) <= 64'(WIDTH_IN)) begin : g_err_shift
    $error("requant_round_pipe: SHIFT_W too narrow for WIDTH_IN");
  end
  if (WIDTH_IN > 62) begin : g_err_wide
    $error("requant_round_pipe: WIDTH_IN above 62 not supported");
  end

  logic                        r_v1;
  logic                        r_v2;
  logic                        w_rdy1;
  logic                        w_rdy2;
  logic                        w_ld1;
  logic                        w_ld2;
  rnd_mode_e                   r_mode;
  logic [NUM_CH*WIDTH_OUT-1:0] w_data;
  logic [NUM_CH-1:0]           w_sat;
  logic [CNT_W-1:0]            r_sat_count;

  assign w_rdy2 = !r_v2 || bus.m_ready;
  assign w_rdy1 = !r_v1 || w_rdy2;
  assign w_ld1  = bus.s_valid && w_rdy1;
  assign w_ld2  = r_v1 && w_rdy2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1   <= 1'b0;
      r_v2   <= 1'b0;
      r_mode <= RND_HALF_EVEN;
    end else begin
      if (w_rdy1) r_v1   <= bus.s_valid;
      if (w_rdy2) r_v2   <= r_v1;
      if (w_ld1)  r_mode <= rnd_mode_e'(bus.s_mode);
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    requant_lane #(
      .WIDTH_IN  (WIDTH_IN),
      .WIDTH_OUT (WIDTH_OUT),
      .IS_SIGNED (IS_SIGNED),
      .SHIFT_W   (SHIFT_W)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .i_ld1   (w_ld1),
      .i_ld2   (w_ld2),
      .i_x     (bus.s_data[k*WIDTH_IN +: WIDTH_IN]),
      .i_shift (bus.s_shift),
      .i_mode  (r_mode),
      .o_y     (w_data[k*WIDTH_OUT +: WIDTH_OUT]),
      .o_sat   (w_sat[k])
    );
  end

  // Clear beats a same-cycle increment; the count sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst || bus.clr_count) begin
      r_sat_count <= '0;
    end else if (r_v2 && bus.m_ready && (|w_sat) && (r_sat_count != c_cnt_max)) begin
      r_sat_count <= r_sat_count + 1'b1;
    end
  end

  assign bus.s_ready   = w_rdy1;
  assign bus.m_valid   = r_v2;
  assign bus.m_data    = w_data;
  assign bus.m_sat     = w_sat;
  assign bus.sat_count = r_sat_count;

endmodule
`default_nettype wire
